// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel line reader: pixel width and FSM state encoding.
package pixel_pkg;

    localparam int unsigned PIXEL_W = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        STREAM    = 2'd2
    } state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry FIFO-ordered skid buffer between the pixel FIFO read port and the output stream.
module pixel_skid_buffer
    import pixel_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [PIXEL_W-1:0] rd_data,
    output logic [1:0]         count
);

    logic [PIXEL_W-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic               pop;

    assign pop = rd_en && (count_q != 2'd0);

    // A write while full is only legal together with a pop; the slot being
    // overwritten is the one leaving, so ordering is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (!wr_en && pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pixel_line_reader.sv
// Streams one frame of pixels from a FIFO to a valid/ready output with SOF/SOL/EOL flags.
// Optional underrun reporting is built when PIXEL_LINE_READER_UNDERRUN_EN is defined.
module pixel_line_reader
    import pixel_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = 640,
    parameter int unsigned FRAME_LINES = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifoEmpty,
    output logic               fifoRdEn,
    input  logic [PIXEL_W-1:0] fifoData,
    output logic               outValid,
    input  logic               outReady,
    output logic [PIXEL_W-1:0] outPixel,
    output logic               outSof,
    output logic               outSol,
    output logic               outEol,
    output logic               underrunIrq,
    output logic [15:0]        underrunCount,
    output logic               busy
);

    localparam int unsigned TOTAL = LINE_WIDTH * FRAME_LINES;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issued_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             inflight_q;
    logic [1:0]       occ;
    logic             xfer;
    logic             col_last;
    logic             row_last;
    logic             frame_end;
    logic             pops_left;

    pixel_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (fifoData),
        .rd_en   (xfer),
        .rd_data (outPixel),
        .count   (occ)
    );

    assign outValid  = (occ != 2'd0);
    assign xfer      = outValid && outReady;
    assign col_last  = (col_q == COL_W'(LINE_WIDTH - 1));
    assign row_last  = (row_q == ROW_W'(FRAME_LINES - 1));
    assign frame_end = xfer && col_last && row_last;
    assign pops_left = (issued_q < CNT_W'(TOTAL));

    // A transfer this cycle frees a skid slot, which keeps the pipe at 1 pixel/cycle.
    assign fifoRdEn = (state_q == STREAM) && !fifoEmpty && pops_left &&
                      (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, xfer}));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (enable) state_d = WAIT_FILL;
            WAIT_FILL: if (!fifoEmpty) state_d = STREAM;
            STREAM:    if (frame_end) state_d = enable ? WAIT_FILL : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifoRdEn;
            if (frame_end) begin
                issued_q <= '0;
            end else if (fifoRdEn) begin
                issued_q <= issued_q + 1'b1;
            end
            if (xfer) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign outSol = outValid && (col_q == '0);
    assign outSof = outSol && (row_q == '0);
    assign outEol = outValid && col_last;

`ifdef PIXEL_LINE_READER_UNDERRUN_EN
    logic        underrun;
    logic        underrun_q;
    logic        irq_q;
    logic [15:0] urun_cnt_q;

    assign underrun = (state_q == STREAM) && (occ == 2'd0) && !inflight_q &&
                      fifoEmpty && pops_left;

    // One event per episode: rising edge of the underrun condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= 1'b0;
            irq_q      <= 1'b0;
            urun_cnt_q <= 16'h0000;
        end else begin
            underrun_q <= underrun;
            irq_q      <= underrun && !underrun_q;
            if (underrun && !underrun_q && (urun_cnt_q != 16'hFFFF)) begin
                urun_cnt_q <= urun_cnt_q + 16'h0001;
            end
        end
    end

    assign underrunIrq   = irq_q;
    assign underrunCount = urun_cnt_q;
`else
    assign underrunIrq   = 1'b0;
    assign underrunCount = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_line_reader.sv
// Directed table-driven bench for pixel_line_reader with a 4x2 frame and a behavioural FIFO.
module tb_pixel_line_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        fifoEmpty = 1'b1;
    logic        fifoRdEn;
    logic [23:0] fifoData = 24'h0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [23:0] outPixel;
    logic        outSof, outSol, outEol;
    logic        underrunIrq;
    logic [15:0] underrunCount;
    logic        busy;

    pixel_line_reader #(
        .LINE_WIDTH  (4),
        .FRAME_LINES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifoEmpty     (fifoEmpty),
        .fifoRdEn      (fifoRdEn),
        .fifoData      (fifoData),
        .outValid      (outValid),
        .outReady      (outReady),
        .outPixel      (outPixel),
        .outSof        (outSof),
        .outSol        (outSol),
        .outEol        (outEol),
        .underrunIrq   (underrunIrq),
        .underrunCount (underrunCount),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data_in;
        logic [23:0] exp_pixel;
        logic        exp_sof;
        logic        exp_sol;
        logic        exp_eol;
    } vec_t;

    vec_t        tbl [8];
    logic [23:0] fq [$];
    logic [23:0] pend_data;
    bit          pend_valid;
    logic [23:0] got_pix [16];
    logic [2:0]  got_flg [16];
    int          got_cyc [16];
    int          n_xfer, n_pop, cyc, irq_pulses;
    int          stall_after, stall_left, drop_after;
    bit          ready_toggle;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, observe 1 time unit later.
    task automatic cycle();
        @(negedge clk);
        if (pend_valid) begin
            fifoData   = pend_data;
            pend_valid = 1'b0;
        end
        fifoEmpty = (fq.size() == 0) || (stall_left > 0);
        if (stall_left > 0) stall_left--;
        outReady = ready_toggle ? ~outReady : 1'b1;
        #1;
        if (outValid && outReady) begin
            if (n_xfer < 16) begin
                got_pix[n_xfer] = outPixel;
                got_flg[n_xfer] = {outSof, outSol, outEol};
                got_cyc[n_xfer] = cyc;
            end
            n_xfer++;
            if (drop_after > 0 && n_xfer == drop_after) enable = 1'b0;
        end
        if (fifoRdEn && !fifoEmpty && fq.size() > 0) begin
            pend_data  = fq.pop_front();
            pend_valid = 1'b1;
            n_pop++;
            if (n_pop == stall_after) stall_left = 5;
        end
        if (underrunIrq === 1'b1) irq_pulses++;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        outReady = 1'b0;
        fifoEmpty = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_frame(input bit do_rst, input bit toggle, input int stall_at,
                               input int drop_at, input logic [23:0] offset, input int extra);
        if (do_rst) apply_reset();
        fq.delete();
        pend_valid   = 1'b0;
        n_xfer       = 0;
        n_pop        = 0;
        cyc          = 0;
        irq_pulses   = 0;
        stall_left   = 0;
        stall_after  = stall_at;
        drop_after   = drop_at;
        ready_toggle = toggle;
        for (int i = 0; i < 8; i++) fq.push_back(tbl[i].data_in + offset);
        for (int i = 0; i < extra; i++) fq.push_back(24'hABCDEF);
        enable = 1'b1;
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 300 && n_xfer < 8; k++) cycle();
        repeat (4) cycle();
    endtask

    task automatic compare_frame(input string tag, input logic [23:0] offset);
        check($sformatf("%s xfer_count", tag), n_xfer, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s pix%0d", tag, i + 1), got_pix[i], tbl[i].exp_pixel + offset);
            check($sformatf("%s flags%0d", tag, i + 1), got_flg[i],
                  {tbl[i].exp_sof, tbl[i].exp_sol, tbl[i].exp_eol});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s busy", tag), busy, 0);
        check($sformatf("%s fifoRdEn", tag), fifoRdEn, 0);
        check($sformatf("%s outValid", tag), outValid, 0);
        check($sformatf("%s outPixel", tag), outPixel, 0);
        check($sformatf("%s flags", tag), {outSof, outSol, outEol}, 0);
        check($sformatf("%s underrunIrq", tag), underrunIrq, 0);
        check($sformatf("%s underrunCount", tag), underrunCount, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'h000001, 24'h000001, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{24'h000002, 24'h000002, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{24'h000003, 24'h000003, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{24'h000004, 24'h000004, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{24'h000005, 24'h000005, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{24'h000006, 24'h000006, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{24'h000007, 24'h000007, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{24'h000008, 24'h000008, 1'b0, 1'b0, 1'b1};
        pend_valid = 1'b0;
        stall_left = 0;
        drop_after = 0;
        ready_toggle = 1'b0;

        #1;
        check_all_zero("reset");

        // Continuous supply and ready: back-to-back transfers.
        start_frame(1'b1, 1'b0, 0, 0, 24'h0, 0);
        finish_frame();
        compare_frame("basic", 24'h0);
        check("basic throughput", got_cyc[7] - got_cyc[0], 7);
        check("basic underrunCount", underrunCount, 0);

        // Ready toggling every cycle.
        start_frame(1'b1, 1'b1, 0, 0, 24'h0, 0);
        finish_frame();
        compare_frame("toggle", 24'h0);

        // FIFO empty for 5 cycles after the third pop.
        start_frame(1'b1, 1'b0, 3, 0, 24'h0, 0);
        finish_frame();
        compare_frame("underrun", 24'h0);
        check("underrun gap", got_cyc[3] - got_cyc[2], 6);
`ifdef PIXEL_LINE_READER_UNDERRUN_EN
        check("underrun irq_pulses", irq_pulses, 1);
        check("underrun count", underrunCount, 1);
`else
        check("underrun irq_pulses", irq_pulses, 0);
        check("underrun count", underrunCount, 0);
`endif

        // Enable dropped after pixel 2; extra FIFO data must stay unread.
        start_frame(1'b1, 1'b0, 0, 2, 24'h0, 4);
        finish_frame();
        compare_frame("drop", 24'h0);
        check("drop busy", busy, 0);
        check("drop fifoRdEn", fifoRdEn, 0);
        check("drop fifo_left", fq.size(), 4);

        // Reset at pixel 5, then a fresh frame from col 0/row 0.
        start_frame(1'b1, 1'b0, 0, 0, 24'h0, 0);
        for (int k = 0; k < 300 && n_xfer < 5; k++) cycle();
        check("midreset reached_pix5", n_xfer, 5);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        start_frame(1'b0, 1'b0, 0, 0, 24'h000010, 0);
        finish_frame();
        compare_frame("after_reset", 24'h000010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
